// File: rtl/fpmul_seq.sv
// Sequential IEEE-754 single-precision multiplier with a radix-2^BITS_PER_CYCLE shift-add core.
// Optional macro ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the result is truncated.
module fpmul_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic [31:0] AxB,
    output logic        DONE,
    output logic [1:0]  EXCEPTION
);
    localparam int N = 24 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {IDLE, UNPACK, CHECK, MULT, NORM, PACK} state_t;

    state_t             state, state_nxt;
    logic [31:0]        op_a, op_b;
    logic               sign;
    logic [7:0]         exp_a, exp_b;
    logic [23:0]        man_a, man_b;
    logic               nan_any, inf_any, zero_any;
    logic signed [9:0]  exp_acc;
    logic [47:0]        acc, mcand, pp_sum;
    logic [23:0]        mplier;
    logic [4:0]         cnt;
    logic [22:0]        mant;
    logic               g, s;
    logic [23:0]        rounded;
    logic signed [9:0]  exp_fin;

    function automatic logic round_inc(input logic guard, input logic sticky, input logic lsb);
`ifdef ROUND_NEAREST_EN
        round_inc = guard & (sticky | lsb);
`else
        round_inc = 1'b0 & (guard | sticky | lsb);
`endif
    endfunction

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = UNPACK;
            UNPACK:  state_nxt = CHECK;
            CHECK:   state_nxt = (nan_any | inf_any | zero_any) ? IDLE : MULT;
            MULT:    if (cnt == 5'(N - 1)) state_nxt = NORM;
            NORM:    state_nxt = PACK;
            PACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Partial products for the multiplier bits retired this cycle
    always_comb begin
        pp_sum = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++)
            if (mplier[k]) pp_sum = pp_sum + (mcand << k);
    end

    assign rounded = {1'b0, mant} + {23'b0, round_inc(g, s, mant[0])};
    assign exp_fin = exp_acc + $signed({9'b0, rounded[23]});

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            op_a      <= '0;
            op_b      <= '0;
            sign      <= 1'b0;
            exp_a     <= '0;
            exp_b     <= '0;
            man_a     <= '0;
            man_b     <= '0;
            nan_any   <= 1'b0;
            inf_any   <= 1'b0;
            zero_any  <= 1'b0;
            exp_acc   <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            mant      <= '0;
            g         <= 1'b0;
            s         <= 1'b0;
            AxB       <= '0;
            DONE      <= 1'b0;
            EXCEPTION <= 2'b00;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    op_a <= InputA;
                    op_b <= InputB;
                end
                UNPACK: begin
                    sign     <= op_a[31] ^ op_b[31];
                    exp_a    <= op_a[30:23];
                    exp_b    <= op_b[30:23];
                    man_a    <= (op_a[30:23] == 8'h00) ? 24'h0 : {1'b1, op_a[22:0]};
                    man_b    <= (op_b[30:23] == 8'h00) ? 24'h0 : {1'b1, op_b[22:0]};
                    nan_any  <= (op_a[30:23] == 8'hFF && op_a[22:0] != 23'h0) ||
                                (op_b[30:23] == 8'hFF && op_b[22:0] != 23'h0);
                    inf_any  <= (op_a[30:23] == 8'hFF && op_a[22:0] == 23'h0) ||
                                (op_b[30:23] == 8'hFF && op_b[22:0] == 23'h0);
                    zero_any <= (op_a[30:23] == 8'h00) || (op_b[30:23] == 8'h00);
                end
                CHECK: begin
                    if (nan_any || (inf_any && zero_any)) begin
                        AxB       <= 32'h7FC00000;
                        EXCEPTION <= 2'b11;
                        DONE      <= 1'b1;
                    end else if (inf_any) begin
                        AxB       <= {sign, 8'hFF, 23'h0};
                        EXCEPTION <= 2'b00;
                        DONE      <= 1'b1;
                    end else if (zero_any) begin
                        AxB       <= {sign, 31'h0};
                        EXCEPTION <= 2'b00;
                        DONE      <= 1'b1;
                    end else begin
                        exp_acc <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
                        acc     <= '0;
                        mcand   <= {24'h0, man_a};
                        mplier  <= man_b;
                        cnt     <= '0;
                    end
                end
                MULT: begin
                    acc    <= acc + pp_sum;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 5'd1;
                end
                NORM: begin
                    if (acc[47]) begin
                        mant    <= acc[46:24];
                        exp_acc <= exp_acc + 10'sd1;
                        g       <= acc[23];
                        s       <= |acc[22:0];
                    end else begin
                        mant <= acc[45:23];
                        g    <= acc[22];
                        s    <= |acc[21:0];
                    end
                end
                PACK: begin
                    DONE <= 1'b1;
                    if (exp_fin >= 10'sd255) begin
                        AxB       <= {sign, 8'hFF, 23'h0};
                        EXCEPTION <= 2'b01;
                    end else if (exp_fin <= 10'sd0) begin
                        AxB       <= {sign, 31'h0};
                        EXCEPTION <= 2'b10;
                    end else begin
                        AxB       <= {sign, exp_fin[7:0], rounded[22:0]};
                        EXCEPTION <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpmul_seq.sv
// Self-checking bench for fpmul_seq: directed vectors scored against an arithmetic reference model.
module tb_fpmul_seq;
    localparam int BPC = 1;
    localparam int N   = 24 / BPC;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        START;
    logic [31:0] InputA, InputB;
    logic [31:0] AxB;
    logic        DONE;
    logic [1:0]  EXCEPTION;

    fpmul_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .InputA(InputA), .InputB(InputB),
        .AxB(AxB), .DONE(DONE), .EXCEPTION(EXCEPTION)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  exc;
        int          lat;
    } mres_t;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  exc;
        bit          has_lit;
        logic [31:0] lit_res;
        logic [1:0]  lit_exc;
        int          done_cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;
    logic [1:0]  last_exc = '0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    function automatic mres_t model(input logic [31:0] a, input logic [31:0] b);
        mres_t r;
        logic s;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, m;
        bit nan_, inf_, zero_;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_  = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0);
        inf_  = (ea == 255 && a[22:0] == 0) || (eb == 255 && b[22:0] == 0);
        zero_ = (ea == 0) || (eb == 0);
        r.lat = 2;
        if (nan_ || (inf_ && zero_)) begin
            r.res = 32'h7FC00000; r.exc = 2'b11;
        end else if (inf_) begin
            r.res = {s, 8'hFF, 23'h0}; r.exc = 2'b00;
        end else if (zero_) begin
            r.res = {s, 31'h0}; r.exc = 2'b00;
        end else begin
            r.lat = N + 4;
            ma = 64'(a[22:0]) | (64'd1 << 23);
            mb = 64'(b[22:0]) | (64'd1 << 23);
            p  = ma * mb;
            e  = ea + eb - 127;
            sh = (p >= (64'd1 << 47)) ? 24 : 23;
            if (sh == 24) e++;
            m = p >> sh;
`ifdef ROUND_NEAREST_EN
            begin : rnd
                longint unsigned rem, half;
                rem  = p & ((64'd1 << sh) - 1);
                half = 64'd1 << (sh - 1);
                if (rem > half || (rem == half && m[0])) m++;
            end
`endif
            if (m == (64'd1 << 24)) begin
                m = m >> 1;
                e++;
            end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'h0}; r.exc = 2'b01;
            end else if (e <= 0) begin
                r.res = {s, 31'h0}; r.exc = 2'b10;
            end else begin
                r.res = {s, 8'(e), m[22:0]}; r.exc = 2'b00;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Single compare process: reset state, DONE timing, result values and output hold
    always @(negedge CLOCK) begin
        if (RESET === 1'b0) begin
            if (cyc >= 1) begin
                chk("reset_axb", AxB, 32'h0);
                chk("reset_done", {31'h0, DONE}, 32'h0);
                chk("reset_exc", {30'h0, EXCEPTION}, 32'h0);
            end
            last_res = '0;
            last_exc = '0;
        end else if (DONE === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'h1, 32'h0);
            end else begin
                chk("done_cycle", cyc, q[0].done_cyc);
                chk("model_axb", AxB, q[0].res);
                chk("model_exc", {30'h0, EXCEPTION}, {30'h0, q[0].exc});
                if (q[0].has_lit) begin
                    chk("literal_axb", AxB, q[0].lit_res);
                    chk("literal_exc", {30'h0, EXCEPTION}, {30'h0, q[0].lit_exc});
                end
                last_res = q[0].res;
                last_exc = q[0].exc;
                void'(q.pop_front());
            end
        end else begin
            if (q.size() != 0 && cyc == q[0].done_cyc)
                chk("done_missing", {31'h0, DONE}, 32'h1);
            chk("hold_axb", AxB, last_res);
            chk("hold_exc", {30'h0, EXCEPTION}, {30'h0, last_exc});
        end
    end

    // Called at a negedge with the DUT in IDLE (or in its DONE cycle)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit has_lit,
                         input logic [31:0] lit_res, input logic [1:0] lit_exc);
        mres_t m;
        exp_t  e;
        m = model(a, b);
        e.res = m.res;
        e.exc = m.exc;
        e.has_lit = has_lit;
        e.lit_res = lit_res;
        e.lit_exc = lit_exc;
        e.done_cyc = cyc + 1 + m.lat;
        START = 1'b1;
        InputA = a;
        InputB = b;
        q.push_back(e);
        @(negedge CLOCK);
        START = 1'b0;
        InputA = $urandom;
        InputB = $urandom;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge CLOCK);
            if (DONE === 1'b1) break;
        end
        if (k == 100) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no DONE within 100 cycles, expected one");
            q.delete();
        end
    endtask

    localparam int NV = 13;
    logic [31:0] va[NV], vb[NV], vr[NV];
    logic [1:0]  ve[NV];

    initial begin
        va[0]  = 32'h40000000; vb[0]  = 32'h40400000; vr[0]  = 32'h40C00000; ve[0]  = 2'b00;
        va[1]  = 32'h3FC00000; vb[1]  = 32'h3FC00000; vr[1]  = 32'h40100000; ve[1]  = 2'b00;
        va[2]  = 32'h7F800000; vb[2]  = 32'h00000000; vr[2]  = 32'h7FC00000; ve[2]  = 2'b11;
        va[3]  = 32'h7F000000; vb[3]  = 32'h7F000000; vr[3]  = 32'h7F800000; ve[3]  = 2'b01;
        va[4]  = 32'h00800000; vb[4]  = 32'h00800000; vr[4]  = 32'h00000000; ve[4]  = 2'b10;
`ifdef ROUND_NEAREST_EN
        va[5]  = 32'h3F800001; vb[5]  = 32'h3FC00000; vr[5]  = 32'h3FC00002; ve[5]  = 2'b00;
`else
        va[5]  = 32'h3F800001; vb[5]  = 32'h3FC00000; vr[5]  = 32'h3FC00001; ve[5]  = 2'b00;
`endif
        va[6]  = 32'hC0000000; vb[6]  = 32'h40400000; vr[6]  = 32'hC0C00000; ve[6]  = 2'b00;
        va[7]  = 32'h7FC00000; vb[7]  = 32'h3F800000; vr[7]  = 32'h7FC00000; ve[7]  = 2'b11;
        va[8]  = 32'h7F800000; vb[8]  = 32'hC0000000; vr[8]  = 32'hFF800000; ve[8]  = 2'b00;
        va[9]  = 32'h00000000; vb[9]  = 32'hC0400000; vr[9]  = 32'h80000000; ve[9]  = 2'b00;
        va[10] = 32'h00000001; vb[10] = 32'h40000000; vr[10] = 32'h00000000; ve[10] = 2'b00;
        va[11] = 32'h3F800000; vb[11] = 32'hBF800000; vr[11] = 32'hBF800000; ve[11] = 2'b00;
        va[12] = 32'h40400000; vb[12] = 32'h40400000; vr[12] = 32'h41100000; ve[12] = 2'b00;

        RESET = 1'b0;
        START = 1'b0;
        InputA = '0;
        InputB = '0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);

        // Directed vectors, each issued in the DONE cycle of the previous one
        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], 1'b1, vr[i], ve[i]);
            wait_done();
        end

        // Random normal operands, model only
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            issue(a, b, 1'b0, '0, '0);
            wait_done();
        end

        // START while busy must be ignored
        issue(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 2'b00);
        repeat (5) @(negedge CLOCK);
        START = 1'b1; InputA = 32'h3F800000; InputB = 32'h3F800000;
        @(negedge CLOCK);
        START = 1'b0;
        wait_done();

        // Reset in the middle of MULT abandons the operation
        repeat (3) @(negedge CLOCK);
        issue(32'h40400000, 32'h40400000, 1'b1, 32'h41100000, 2'b00);
        repeat (11) @(negedge CLOCK);
        #2 RESET = 1'b0;
        q.delete();
        repeat (2) @(negedge CLOCK);
        #2 RESET = 1'b1;
        repeat (30) @(negedge CLOCK);
        issue(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 2'b00);
        wait_done();
        repeat (3) @(negedge CLOCK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
